toggle_rate_sequencer: RTL and testbench

Drives the 4-bit toggle-rate select of the toggle-stress array, which picks one of counter bits 0..15 as the shift-in source: select 0 is the fastest toggle, 15 the slowest. Replaces a static select with a programmable profile. The profile steps the select through a range, holds each value for a programmable dwell, and either finishes or loops. This lets power and thermal load be ramped in a controlled way. The block sits directly upstream of the stress array and connects to its `toggle_change` input.

---
 rtl/toggle_seq_pkg.sv | 35 +++
 rtl/toggle_dwell_timer.sv | 38 +++
 rtl/toggle_rate_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_toggle_rate_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/toggle_seq_pkg.sv
// Shared definitions for the toggle-rate sequencer: mode and state
// encodings, the park select, the TRIANGLE direction flag and the
// first-step helper.
package toggle_seq_pkg;

  localparam int unsigned SEL_W = 4;

  localparam logic [SEL_W-1:0] PARK_SEL_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    MODE_ASC  = 2'b00,
    MODE_DESC = 2'b01,
    MODE_TRI  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // TRIANGLE walks up to the peak, then down to min.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } tri_dir_e;

  // Select for the first step of a profile.
  function automatic logic [SEL_W-1:0] first_sel(input mode_e m,
                                                  input logic [SEL_W-1:0] lo,
                                                  input logic [SEL_W-1:0] hi);
    return (m == MODE_DESC) ? hi : lo;
  endfunction

endpackage

// File: rtl/toggle_dwell_timer.sv
// Per-step dwell down-counter.
//   clk, rst : clock, async active-high reset
//   load     : start a new step; count value max(dwell,1)
//   dwell    : cycles per step (0 treated as 1)
//   expire   : high on the last cycle of the step
module toggle_dwell_timer
  import toggle_seq_pkg::*;
#(
  parameter int unsigned DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q;

  // cnt_q holds the cycles remaining after the current one; expire is
  // registered so it lines up with the step's final cycle. A load wins
  // over the natural count, so load+expire reloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      expire <= 1'b0;
    end else if (load) begin
      cnt_q  <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
      expire <= (dwell <= DWELL_W'(1));
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - DWELL_W'(1);
      expire <= (cnt_q == DWELL_W'(1));
    end else begin
      expire <= 1'b0;
    end
  end

endmodule

// File: rtl/toggle_rate_sequencer.sv
// Programmable profile driver for the stress-array toggle-rate select.
//   clk, rst        : clock, async active-high reset
//   start, stop     : run request (IDLE only) / abort (any state)
//   mode, loop      : profile shape and repeat enable
//   sel_min/sel_max : select bounds; dwell : cycles per step
//   toggle_change   : select to the stress array (PARK_SEL when idle)
//   busy, step_strobe, done, cfg_err : status, all registered
module toggle_rate_sequencer
  import toggle_seq_pkg::*;
#(
  parameter int unsigned DWELL_W  = 24,
  parameter logic [3:0]  PARK_SEL = PARK_SEL_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic               loop,
  input  logic [3:0]         sel_min,
  input  logic [3:0]         sel_max,
  input  logic [DWELL_W-1:0] dwell,
  output logic [3:0]         toggle_change,
  output logic               busy,
  output logic               step_strobe,
  output logic               done,
  output logic               cfg_err
);

  state_e             state_q, state_d;
  tri_dir_e           dir_q, dir_d;
  mode_e              mode_q, mode_d;
  logic               loop_q, loop_d;
  logic [3:0]         min_q, min_d, max_q, max_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [3:0]         sel_q, sel_d;
  logic               busy_d, strobe_d, done_d, err_d;

  logic               timer_load, timer_expire;
  logic [DWELL_W-1:0] timer_dwell;
  logic               last;
  logic [3:0]         nxt_sel;
  tri_dir_e           nxt_dir;

  // First step loads from the live input; later steps from the latched copy.
  assign timer_dwell = (state_q == ST_IDLE) ? dwell : dwell_q;

  toggle_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .dwell  (timer_dwell),
    .expire (timer_expire)
  );

  // Successor step; compare-before-step keeps the select from wrapping.
  always_comb begin
    last    = 1'b0;
    nxt_sel = sel_q;
    nxt_dir = dir_q;
    if (min_q == max_q) begin
      last = 1'b1;
    end else begin
      unique case (mode_q)
        MODE_ASC: begin
          if (sel_q == max_q) last = 1'b1;
          else                nxt_sel = sel_q + 4'd1;
        end
        MODE_DESC: begin
          if (sel_q == min_q) last = 1'b1;
          else                nxt_sel = sel_q - 4'd1;
        end
        MODE_TRI: begin
          if (dir_q == DIR_UP) begin
            if (sel_q == max_q) begin
              nxt_dir = DIR_DOWN;
              nxt_sel = sel_q - 4'd1;
            end else begin
              nxt_sel = sel_q + 4'd1;
            end
          end else if (sel_q == min_q) begin
            last = 1'b1;
          end else begin
            nxt_sel = sel_q - 4'd1;
          end
        end
        MODE_HOLD: last = 1'b1;
      endcase
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    mode_d     = mode_q;
    loop_d     = loop_q;
    min_d      = min_q;
    max_d      = max_q;
    dwell_d    = dwell_q;
    sel_d      = sel_q;
    busy_d     = busy;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    timer_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          if (sel_min > sel_max) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_RUN;
            mode_d     = mode_e'(mode);
            loop_d     = loop;
            min_d      = sel_min;
            max_d      = sel_max;
            dwell_d    = dwell;
            sel_d      = first_sel(mode_e'(mode), sel_min, sel_max);
            dir_d      = DIR_UP;
            busy_d     = 1'b1;
            strobe_d   = 1'b1;
            timer_load = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          sel_d   = PARK_SEL;
          busy_d  = 1'b0;
        end else if (timer_expire) begin
          if (!last) begin
            sel_d      = nxt_sel;
            dir_d      = nxt_dir;
            strobe_d   = 1'b1;
            timer_load = 1'b1;
          end else if (loop_q) begin
            sel_d      = first_sel(mode_q, min_q, max_q);
            dir_d      = DIR_UP;
            strobe_d   = 1'b1;
            timer_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            sel_d   = PARK_SEL;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_UP;
      mode_q      <= MODE_ASC;
      loop_q      <= 1'b0;
      min_q       <= '0;
      max_q       <= '0;
      dwell_q     <= '0;
      sel_q       <= PARK_SEL;
      busy        <= 1'b0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      loop_q      <= loop_d;
      min_q       <= min_d;
      max_q       <= max_d;
      dwell_q     <= dwell_d;
      sel_q       <= sel_d;
      busy        <= busy_d;
      step_strobe <= strobe_d;
      done        <= done_d;
      cfg_err     <= err_d;
    end
  end

  assign toggle_change = sel_q;

endmodule

// File: tb/tb_toggle_rate_sequencer.sv
// Directed bench for toggle_rate_sequencer with hand-computed expectations.
module tb_toggle_rate_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, loop;
  logic [1:0]  mode;
  logic [3:0]  sel_min, sel_max;
  logic [23:0] dwell;
  logic [3:0]  toggle_change;
  logic        busy, step_strobe, done, cfg_err;

  int vectors     = 0;
  int miscompares = 0;

  toggle_rate_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .mode          (mode),
    .loop          (loop),
    .sel_min       (sel_min),
    .sel_max       (sel_max),
    .dwell         (dwell),
    .toggle_change (toggle_change),
    .busy          (busy),
    .step_strobe   (step_strobe),
    .done          (done),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " sel"},    32'(toggle_change), 32'hF);
    check_eq({tag, " busy"},   32'(busy), 0);
    check_eq({tag, " strobe"}, 32'(step_strobe), 0);
  endtask

  int tri_pat[5] = '{0, 1, 2, 1, 0};

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; mode = 2'b00;
    sel_min = '0; sel_max = '0; dwell = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check_eq("reset done", 32'(done), 0);
    check_eq("reset err", 32'(cfg_err), 0);
    rst = 1'b0;
    tick();
    check_idle("post-reset");

    // ASCEND 3..6, dwell 2
    mode = 2'b00; loop = 1'b0; sel_min = 4'd3; sel_max = 4'd6; dwell = 24'd2;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start = 1'b0;
      check_eq("asc sel", 32'(toggle_change), 32'(3 + i / 2));
      check_eq("asc strobe", 32'(step_strobe), 32'((i % 2) == 0));
      check_eq("asc busy", 32'(busy), 1);
      check_eq("asc done", 32'(done), 0);
    end
    tick();
    check_idle("asc end");
    check_eq("asc done pulse", 32'(done), 1);
    tick();
    check_eq("asc done clear", 32'(done), 0);

    // TRIANGLE 0..2, dwell 0, looping, stopped at cycle 10
    mode = 2'b10; loop = 1'b1; sel_min = 4'd0; sel_max = 4'd2; dwell = 24'd0;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      start = 1'b0;
      check_eq("tri sel", 32'(toggle_change), 32'(tri_pat[i % 5]));
      check_eq("tri strobe", 32'(step_strobe), 1);
      check_eq("tri busy", 32'(busy), 1);
      if (i == 9) stop = 1'b1;
    end
    tick();
    stop = 1'b0;
    check_idle("tri stop");
    check_eq("tri no done", 32'(done), 0);
    tick();
    check_eq("tri no done2", 32'(done), 0);

    // Bad bounds
    mode = 2'b00; loop = 1'b0; sel_min = 4'd9; sel_max = 4'd4; dwell = 24'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("cfg err pulse", 32'(cfg_err), 1);
    check_idle("cfg err");
    tick();
    check_eq("cfg err clear", 32'(cfg_err), 0);
    check_idle("cfg err after");

    // HOLD at 15, dwell 5; start+stop together is dropped
    mode = 2'b11; sel_min = 4'd15; sel_max = 4'd15; dwell = 24'd5;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_idle("start+stop");
    check_eq("start+stop err", 32'(cfg_err), 0);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold sel", 32'(toggle_change), 32'hF);
      check_eq("hold busy", 32'(busy), 1);
      check_eq("hold strobe", 32'(step_strobe), 32'(i == 0));
      check_eq("hold done", 32'(done), 0);
      start = (i == 1);
    end
    start = 1'b0;
    tick();
    check_idle("hold end");
    check_eq("hold done pulse", 32'(done), 1);
    tick();
    check_idle("hold after");
    check_eq("hold done clear", 32'(done), 0);

    // DESCEND 15..0, dwell 1; bound change mid-run ignored
    mode = 2'b01; loop = 1'b0; sel_min = 4'd0; sel_max = 4'd15; dwell = 24'd1;
    start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      start = 1'b0;
      if (i == 3) sel_min = 4'd8;
      check_eq("desc sel", 32'(toggle_change), 32'(15 - i));
      check_eq("desc strobe", 32'(step_strobe), 1);
      check_eq("desc busy", 32'(busy), 1);
    end
    tick();
    check_idle("desc end");
    check_eq("desc done pulse", 32'(done), 1);

    // Asynchronous reset mid-run
    tick();
    mode = 2'b00; sel_min = 4'd0; sel_max = 4'd15; dwell = 24'd3;
    start = 1'b1;
    repeat (4) begin
      tick();
      start = 1'b0;
    end
    check_eq("pre-rst busy", 32'(busy), 1);
    check_eq("pre-rst sel", 32'(toggle_change), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle("async rst");
    check_eq("async rst done", 32'(done), 0);
    tick();
    check_idle("rst held");
    rst = 1'b0;
    tick();
    check_idle("rst released");
    check_eq("rst released done", 32'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
